fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 5-stage MIPS core. It sits between the PC register, instruction memory and the IF/ID pipeline register, and computes `pc_next` every cycle. It runs a single-outstanding request/ack handshake with instruction memory, holds the PC under hazard stalls and applies exception, branch and jump redirects. It squashes any in-flight fetch that a redirect makes stale.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_ctrl_pc_sel.sv | 40 ++++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the 5-stage MIPS core.
//   fetch_state_t  - instruction-fetch sequencer states
//   RESET_PC       - PC value loaded by the PC register on reset
//   EXC_VECTOR_DEF - default exception handler address
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC       = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;

endpackage

// File: rtl/fetch_ctrl_pc_sel.sv
// pc_sel: combinational next-PC selection for the fetch sequencer.
//   pc_i, pc_4_i      current PC and PC+4
//   adv_i             fetch completed this cycle (advance to pc_4_i)
//   exc_i             exception redirect (highest priority)
//   br_taken_i/_target_i  branch redirect
//   jmp_i/jmp_target_i    jump redirect (lowest priority)
//   pc_next_o         selected next PC
//   flush_o           any redirect active
module pc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_4_i,
    input  logic        adv_i,
    input  logic        exc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    output logic [31:0] pc_next_o,
    output logic        flush_o
);

    logic [31:0] target;

    always_comb begin
        target  = jmp_target_i;
        flush_o = exc_i | br_taken_i | jmp_i;
        if (exc_i)           target = EXC_VECTOR;
        else if (br_taken_i) target = br_target_i;

        // Instructions are word aligned; low address bits are never honoured.
        if (flush_o)    pc_next_o = {target[31:2], 2'b00};
        else if (adv_i) pc_next_o = pc_4_i;
        else            pc_next_o = pc_i;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Drives a single-outstanding
// req/ack handshake to instruction memory, loads the IF/ID register,
// holds under hazard stalls and applies exception/branch/jump redirects,
// squashing any in-flight fetch a redirect has made stale.
//   clk, rst_n           clock, asynchronous active-low reset
//   pc, pc_4, pc_next    PC register interface (pc_next combinational)
//   stall_i              hazard stall for IF/ID
//   exc_i, br_*, jmp_*   redirect requests and targets
//   imem_req_o/addr_o    fetch request and address
//   imem_ack_i/rdata_i   fetch completion and instruction
//   if_valid_o/instr_o/pc_o  registered IF/ID entry
//   flush_o              combinational flush on any redirect
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] pc_4,
    output logic [31:0] pc_next,
    input  logic        stall_i,
    input  logic        exc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        flush_o
);

    fetch_state_t state_q;
    logic         req_q;
    logic [31:0]  req_addr_q;
    logic [31:0]  hold_instr_q;
    logic [31:0]  hold_pc_q;
    logic         if_valid_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc_q;
    logic         adv;

    // The PC only advances when the fetch of the current PC completes.
    assign adv = (state_q == FETCH) && imem_ack_i;

    pc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_pc_sel (
        .pc_i         (pc),
        .pc_4_i       (pc_4),
        .adv_i        (adv),
        .exc_i        (exc_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .pc_next_o    (pc_next),
        .flush_o      (flush_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
        end else begin
            if (state_q == FETCH) req_addr_q <= pc;

            if (flush_o) begin
                // A redirect kills the IF/ID entry regardless of stall. An
                // unacked request must still be completed (and discarded) in
                // SQUASH to keep a single request outstanding.
                if_valid_q <= 1'b0;
                req_q      <= 1'b1;
                if ((state_q == FETCH || state_q == SQUASH) && !imem_ack_i)
                    state_q <= SQUASH;
                else
                    state_q <= FETCH;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                    FETCH: begin
                        if (imem_ack_i) begin
                            if (!stall_i) begin
                                if_valid_q <= 1'b1;
                                if_instr_q <= imem_rdata_i;
                                if_pc_q    <= pc;
                            end else begin
                                hold_instr_q <= imem_rdata_i;
                                hold_pc_q    <= pc;
                                state_q      <= HOLD;
                                req_q        <= 1'b0;
                            end
                        end else if (!stall_i) begin
                            if_valid_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= hold_instr_q;
                            if_pc_q    <= hold_pc_q;
                            state_q    <= FETCH;
                            req_q      <= 1'b1;
                        end
                    end
                    SQUASH: begin
                        if (imem_ack_i) state_q <= FETCH;
                    end
                    default: begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // SQUASH replays the stale address so the request stays stable to ack.
    assign imem_req_o  = req_q;
    assign imem_addr_o = (state_q == SQUASH) ? req_addr_q : pc;
    assign if_valid_o  = if_valid_q;
    assign if_instr_o  = if_instr_q;
    assign if_pc_o     = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_q;
    logic [31:0] pc_4;
    logic [31:0] pc_next;
    logic        stall_i = 1'b0;
    logic        exc_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        flush_o;

    int          vectors = 0;
    int          miscompares = 0;

    // Memory model: ack after mem_lat extra cycles of request, or forced.
    logic        ack_force = 1'b0;
    logic        mem_en = 1'b0;
    int          mem_lat = 0;
    int          mem_cnt;

    always #5 clk = ~clk;

    assign pc_4         = pc_q + 32'd4;
    assign imem_ack_i   = ack_force | (mem_en & imem_req_o & (mem_cnt == mem_lat));
    assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (!imem_req_o || imem_ack_i) mem_cnt <= 0;
        else                           mem_cnt <= mem_cnt + 1;
    end

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc_q),
        .pc_4         (pc_4),
        .pc_next      (pc_next),
        .stall_i      (stall_i),
        .exc_i        (exc_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .flush_o      (flush_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release; on return the DUT is in IDLE for the current cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0; exc_i = 1'b0; br_taken_i = 1'b0; jmp_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        ack_force = 1'b1; mem_en = 1'b0;
        rst_n = 1'b0;
        tick();
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got %h want 0", imem_req_o); end
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %h want 0", if_valid_o); end
        vectors++; if (if_pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_ifpc got %h want 0", if_pc_o); end
        vectors++; if (if_instr_o !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want 0", if_instr_o); end
        vectors++; if (flush_o !== 1'b0) begin miscompares++; $display("FAIL rst_flush got %h want 0", flush_o); end
        rst_n = 1'b1;
        #1;
        // IDLE: ack is ignored, pc_next stays on pc
        vectors++; if (pc_next !== 32'h0040_0000) begin miscompares++; $display("FAIL idle_pcnext got %h want 00400000", pc_next); end
        tick();
        vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL first_req got %h want 1", imem_req_o); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_addr_o !== 32'h0040_0000 + 32'(4 * i)) begin miscompares++; $display("FAIL zw_addr%0d got %h want %h", i, imem_addr_o, 32'h0040_0000 + 32'(4 * i)); end
            if (i > 0) begin
                vectors++; if (if_pc_o !== 32'h0040_0000 + 32'(4 * (i - 1))) begin miscompares++; $display("FAIL zw_ifpc%0d got %h want %h", i, if_pc_o, 32'h0040_0000 + 32'(4 * (i - 1))); end
                vectors++; if (if_instr_o !== ((32'h0040_0000 + 32'(4 * (i - 1))) ^ 32'hA5A5_0000)) begin miscompares++; $display("FAIL zw_instr%0d got %h", i, if_instr_o); end
                vectors++; if (if_valid_o !== 1'b1) begin miscompares++; $display("FAIL zw_valid%0d got %h want 1", i, if_valid_o); end
            end
            tick();
        end
    endtask

    task automatic test_stall_on_ack();
        ack_force = 1'b1; mem_en = 1'b0;
        do_reset();
        tick();          // FETCH 0x00400000
        tick();          // FETCH 0x00400004
        stall_i = 1'b1;
        #1;
        vectors++; if (pc_next !== 32'h0040_0008) begin miscompares++; $display("FAIL stall_pcnext got %h want 00400008", pc_next); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL hold_req%0d got %h want 0", i, imem_req_o); end
            vectors++; if (if_pc_o !== 32'h0040_0000) begin miscompares++; $display("FAIL hold_ifpc%0d got %h want 00400000", i, if_pc_o); end
        end
        stall_i = 1'b0;
        tick();
        vectors++; if (if_pc_o !== 32'h0040_0004) begin miscompares++; $display("FAIL release_ifpc got %h want 00400004", if_pc_o); end
        vectors++; if (if_valid_o !== 1'b1) begin miscompares++; $display("FAIL release_valid got %h want 1", if_valid_o); end
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0008) begin miscompares++; $display("FAIL release_fetch got req %h addr %h want 1 00400008", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_branch_mid_fetch();
        int guard;
        ack_force = 1'b0; mem_en = 1'b1; mem_lat = 2;
        do_reset();
        guard = 0;
        while (!(imem_req_o && imem_addr_o == 32'h0040_0010) && guard < 100) begin
            tick();
            guard++;
        end
        vectors++; if (guard >= 100) begin miscompares++; $display("FAIL br_reach got addr %h want 00400010 within 100 cycles", imem_addr_o); end
        tick();          // second cycle of the 0x00400010 request
        br_taken_i = 1'b1; br_target_i = 32'h0040_0100;
        #1;
        vectors++; if (pc_next !== 32'h0040_0100) begin miscompares++; $display("FAIL br_pcnext got %h want 00400100", pc_next); end
        vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL br_flush got %h want 1", flush_o); end
        tick();
        br_taken_i = 1'b0;
        #1;
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0010) begin miscompares++; $display("FAIL squash_addr got req %h addr %h want 1 00400010", imem_req_o, imem_addr_o); end
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL squash_valid got %h want 0", if_valid_o); end
        vectors++; if (pc_next !== 32'h0040_0100) begin miscompares++; $display("FAIL squash_pcnext got %h want 00400100", pc_next); end
        tick();          // squashed ack landed on the previous edge
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL squash_discard got %h want 0", if_valid_o); end
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0100) begin miscompares++; $display("FAIL br_newreq got req %h addr %h want 1 00400100", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_simultaneous_redirects();
        ack_force = 1'b1; mem_en = 1'b0;
        do_reset();
        tick();
        tick();
        exc_i = 1'b1; br_taken_i = 1'b1; jmp_i = 1'b1;
        br_target_i = 32'h1234_5678; jmp_target_i = 32'h0bad_0000;
        #1;
        vectors++; if (pc_next !== 32'h8000_0180) begin miscompares++; $display("FAIL all3_pcnext got %h want 80000180", pc_next); end
        exc_i = 1'b0; br_target_i = 32'h0040_0203;
        #1;
        vectors++; if (pc_next !== 32'h0040_0200) begin miscompares++; $display("FAIL br_align got %h want 00400200", pc_next); end
        br_taken_i = 1'b0; jmp_target_i = 32'h0040_0302;
        #1;
        vectors++; if (pc_next !== 32'h0040_0300) begin miscompares++; $display("FAIL jmp_align got %h want 00400300", pc_next); end
        vectors++; if (flush_o !== 1'b1) begin miscompares++; $display("FAIL jmp_flush got %h want 1", flush_o); end
        stall_i = 1'b1;  // redirect must override the stall
        tick();
        jmp_i = 1'b0; stall_i = 1'b0;
        #1;
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %h want 0", if_valid_o); end
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0300) begin miscompares++; $display("FAIL redir_fetch got req %h addr %h want 1 00400300", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_reset_mid_request();
        ack_force = 1'b0; mem_en = 1'b1; mem_lat = 2;
        do_reset();
        tick();
        tick();
        tick();          // request for 0x0040_0000 still outstanding
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL midrst_req got %h want 0", imem_req_o); end
        vectors++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin miscompares++; $display("FAIL midrst_ifid got %h %h %h want 0 0 0", if_valid_o, if_pc_o, if_instr_o); end
        tick();
        rst_n = 1'b1;
        ack_force = 1'b1;  // stray ack with no request
        #1;
        vectors++; if (pc_next !== 32'h0040_0000) begin miscompares++; $display("FAIL stray_pcnext got %h want 00400000", pc_next); end
        tick();
        ack_force = 1'b0;
        #1;
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL stray_valid got %h want 0", if_valid_o); end
        vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0000) begin miscompares++; $display("FAIL postrst_req got req %h addr %h want 1 00400000", imem_req_o, imem_addr_o); end
    endtask

    initial begin
        test_reset();
        test_stall_on_ack();
        test_branch_mid_fetch();
        test_simultaneous_redirects();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
